// File: rtl/ack_eoi_controller_8259.sv
// 8259 interrupt-acknowledge sequencer plus EOI / priority-rotation control.
// Every flop updates on the falling clock edge, in step with the in-service register.
module ack_eoi_controller_8259 #(
  parameter logic [2:0] RESET_ROTATE = 3'b111
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       interrupt_acknowledge_n,
  input  logic [7:0] interrupt,
  input  logic [7:0] highest_level_in_service,
  input  logic       icw1_write,
  input  logic       icw4_upm,
  input  logic       icw4_aeoi,
  input  logic       ocw2_write,
  input  logic [7:0] ocw2_data,
  output logic       latch_in_service,
  output logic [7:0] end_of_interrupt,
  output logic [2:0] priority_rotate,
  output logic [2:0] acknowledged_level,
  output logic       spurious,
  output logic       vector_output_enable,
  output logic [1:0] vector_byte_select
);

  typedef enum logic [1:0] {StIdle, StAck1, StAck2, StAck3} state_e;

  state_e     state;
  logic       prev_inta;
  logic       rotate_in_aeoi;
  logic       inta_fall, inta_rise, seq_end, aeoi_fire;
  logic [7:0] aeoi_mask, ocw2_mask;
  logic       ocw2_rotate_en;
  logic [2:0] ocw2_rotate;

  function automatic logic [2:0] encode(input logic [7:0] onehot);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (onehot[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  assign inta_fall = prev_inta & ~interrupt_acknowledge_n;
  assign inta_rise = ~prev_inta & interrupt_acknowledge_n;
  // Final pulse: 2nd in 8086 mode (leaving ACK2), 3rd in 8080 mode (leaving ACK3).
  assign seq_end   = inta_rise & (((state == StAck2) & icw4_upm) | (state == StAck3));
  assign aeoi_fire = seq_end & icw4_aeoi & ~spurious;
  assign aeoi_mask = aeoi_fire ? (8'h01 << acknowledged_level) : 8'h00;

  always_comb begin
    ocw2_mask      = 8'h00;
    ocw2_rotate_en = 1'b0;
    ocw2_rotate    = ocw2_data[2:0];
    if (ocw2_write) begin
      case (ocw2_data[7:5])
        3'b001: ocw2_mask = highest_level_in_service;
        3'b011: ocw2_mask = 8'h01 << ocw2_data[2:0];
        3'b101: begin
          ocw2_mask      = highest_level_in_service;
          ocw2_rotate_en = |highest_level_in_service;
          ocw2_rotate    = encode(highest_level_in_service);
        end
        3'b111: begin
          ocw2_mask      = 8'h01 << ocw2_data[2:0];
          ocw2_rotate_en = 1'b1;
        end
        3'b110:  ocw2_rotate_en = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state                <= StIdle;
      prev_inta            <= 1'b1;
      rotate_in_aeoi       <= 1'b0;
      latch_in_service     <= 1'b0;
      end_of_interrupt     <= 8'h00;
      priority_rotate      <= RESET_ROTATE;
      acknowledged_level   <= 3'd0;
      spurious             <= 1'b0;
      vector_output_enable <= 1'b0;
      vector_byte_select   <= 2'd0;
    end else if (icw1_write) begin
      state                <= StIdle;
      prev_inta            <= 1'b1;
      rotate_in_aeoi       <= 1'b0;
      latch_in_service     <= 1'b0;
      end_of_interrupt     <= 8'h00;
      priority_rotate      <= RESET_ROTATE;
      acknowledged_level   <= 3'd0;
      spurious             <= 1'b0;
      vector_output_enable <= 1'b0;
      vector_byte_select   <= 2'd0;
    end else begin
      prev_inta        <= interrupt_acknowledge_n;
      latch_in_service <= 1'b0;
      end_of_interrupt <= aeoi_mask | ocw2_mask;

      // OCW2 rotation overrides an AEOI rotation landing in the same cycle.
      if (ocw2_rotate_en) begin
        priority_rotate <= ocw2_rotate;
      end else if (aeoi_fire && rotate_in_aeoi) begin
        priority_rotate <= acknowledged_level;
      end

      if (ocw2_write && ocw2_data[7:5] == 3'b100) rotate_in_aeoi <= 1'b1;
      if (ocw2_write && ocw2_data[7:5] == 3'b000) rotate_in_aeoi <= 1'b0;

      if (inta_rise) begin
        vector_output_enable <= 1'b0;
        vector_byte_select   <= 2'd0;
      end

      unique case (state)
        StIdle: begin
          if (inta_fall) begin
            state                <= StAck1;
            latch_in_service     <= |interrupt;
            spurious             <= ~|interrupt;
            acknowledged_level   <= (|interrupt) ? encode(interrupt) : 3'd7;
            vector_output_enable <= ~icw4_upm;
            vector_byte_select   <= icw4_upm ? 2'd0 : 2'd1;
          end
        end
        StAck1: begin
          if (inta_fall) begin
            state                <= StAck2;
            vector_output_enable <= 1'b1;
            vector_byte_select   <= 2'd2;
          end
        end
        StAck2: begin
          if (inta_fall && !icw4_upm) begin
            state                <= StAck3;
            vector_output_enable <= 1'b1;
            vector_byte_select   <= 2'd3;
          end else if (seq_end) begin
            state    <= StIdle;
            spurious <= 1'b0;
          end
        end
        StAck3: begin
          if (seq_end) begin
            state    <= StIdle;
            spurious <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ack_eoi_controller_8259.sv
// Randomized self-checking bench for ack_eoi_controller_8259 with a pulse-level reference model.
module tb_ack_eoi_controller_8259;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       inta_n = 1'b1;
  logic [7:0] interrupt = 8'h00;
  logic [7:0] highest = 8'h00;
  logic       icw1_write = 1'b0;
  logic       icw4_upm = 1'b1;
  logic       icw4_aeoi = 1'b0;
  logic       ocw2_write = 1'b0;
  logic [7:0] ocw2_data = 8'h00;

  logic       latch_in_service;
  logic [7:0] end_of_interrupt;
  logic [2:0] priority_rotate;
  logic [2:0] acknowledged_level;
  logic       spurious;
  logic       vector_output_enable;
  logic [1:0] vector_byte_select;

  int tests = 0;
  int fails = 0;

  // Reference model state: what the outputs must read after the current cycle.
  logic       exp_latch, exp_spur, exp_voe, exp_raie;
  logic [7:0] exp_eoi;
  logic [2:0] exp_rot, exp_lvl;
  logic [1:0] exp_sel;

  wire [18:0] obs = {latch_in_service, end_of_interrupt, priority_rotate, acknowledged_level,
                     spurious, vector_output_enable, vector_byte_select};

  always #5 clock = ~clock;

  ack_eoi_controller_8259 dut (
    .clock                   (clock),
    .reset_n                 (reset_n),
    .interrupt_acknowledge_n (inta_n),
    .interrupt               (interrupt),
    .highest_level_in_service(highest),
    .icw1_write              (icw1_write),
    .icw4_upm                (icw4_upm),
    .icw4_aeoi               (icw4_aeoi),
    .ocw2_write              (ocw2_write),
    .ocw2_data               (ocw2_data),
    .latch_in_service        (latch_in_service),
    .end_of_interrupt        (end_of_interrupt),
    .priority_rotate         (priority_rotate),
    .acknowledged_level      (acknowledged_level),
    .spurious                (spurious),
    .vector_output_enable    (vector_output_enable),
    .vector_byte_select      (vector_byte_select)
  );

  function automatic logic [18:0] expv();
    return {exp_latch, exp_eoi, exp_rot, exp_lvl, exp_spur, exp_voe, exp_sel};
  endfunction

  // Inputs change just after the rising edge; the DUT acts on the falling edge.
  task automatic tick();
    @(posedge clock);
  endtask

  task automatic idle_exp();
    exp_latch = 1'b0; exp_eoi = 8'h00; exp_voe = 1'b0; exp_sel = 2'd0;
  endtask

  task automatic reset_exp();
    idle_exp();
    exp_rot = 3'd7; exp_lvl = 3'd0; exp_spur = 1'b0; exp_raie = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    reset_n = 1'b0;
    #1;
    reset_exp();
    tests++;
    if (obs !== expv()) begin fails++; $display("FAIL reset: got %h exp %h", obs, expv()); end
    tick(); tick();
    reset_n = 1'b1;
    tick();
    tests++;
    if (obs !== expv()) begin fails++; $display("FAIL reset_release: got %h exp %h", obs, expv()); end
  endtask

  // Random INTA sequences in both modes, with random AEOI / rotate-in-AEOI / spurious cases.
  task automatic test_ack();
    logic       upm, aeoi, raie;
    logic [2:0] lvl;
    logic [7:0] irq;
    int         np, hold, gap;
    for (int it = 0; it < 24; it++) begin
      upm  = 1'($urandom_range(0, 1));
      aeoi = 1'($urandom_range(0, 1));
      raie = 1'($urandom_range(0, 1));
      lvl  = 3'($urandom_range(0, 7));
      irq  = ($urandom_range(0, 4) == 0) ? 8'h00 : (8'h01 << lvl);
      icw4_upm = upm; icw4_aeoi = aeoi; highest = 8'h00;
      ocw2_data = raie ? 8'h80 : 8'h00; ocw2_write = 1'b1;
      tick();
      ocw2_write = 1'b0;
      idle_exp(); exp_raie = raie;
      tests++;
      if (obs !== expv()) begin fails++; $display("FAIL ack_setup it%0d: got %h exp %h", it, obs, expv()); end
      interrupt = irq;
      np = upm ? 2 : 3;
      for (int p = 1; p <= np; p++) begin
        inta_n = 1'b0;
        hold = $urandom_range(1, 3);
        for (int h = 0; h < hold; h++) begin
          tick();
          if (p == 1 && h == 0) begin
            exp_spur = (irq == 8'h00);
            exp_lvl  = exp_spur ? 3'd7 : lvl;
          end
          exp_latch = (p == 1 && h == 0 && irq != 8'h00);
          exp_eoi   = 8'h00;
          exp_voe   = upm ? (p == 2) : 1'b1;
          exp_sel   = upm ? ((p == 2) ? 2'd2 : 2'd0) : 2'(p);
          tests++;
          if (obs !== expv()) begin
            fails++; $display("FAIL ack_low it%0d p%0d h%0d: got %h exp %h", it, p, h, obs, expv());
          end
        end
        // The captured level must not follow the request lines after the first pulse.
        if (p == 1) interrupt = 8'($urandom);
        inta_n = 1'b1;
        tick();
        idle_exp();
        if (p == np) begin
          if (aeoi && !exp_spur) begin
            exp_eoi = 8'h01 << exp_lvl;
            if (exp_raie) exp_rot = exp_lvl;
          end
          exp_spur = 1'b0;
        end
        tests++;
        if (obs !== expv()) begin
          fails++; $display("FAIL ack_rise it%0d p%0d: got %h exp %h", it, p, obs, expv());
        end
        gap = $urandom_range(1, 3);
        for (int g = 0; g < gap; g++) begin
          tick();
          idle_exp();
          tests++;
          if (obs !== expv()) begin
            fails++; $display("FAIL ack_gap it%0d p%0d: got %h exp %h", it, p, obs, expv());
          end
        end
      end
    end
  endtask

  task automatic test_ocw2();
    logic [7:0] tab_data [4] = '{8'hA0, 8'h63, 8'hC6, 8'h20};
    logic [7:0] tab_high [4] = '{8'h04, 8'h04, 8'h04, 8'h00};
    logic [7:0] tab_eoi  [4] = '{8'h04, 8'h08, 8'h00, 8'h00};
    logic [2:0] tab_rot  [4] = '{3'd2, 3'd2, 3'd6, 3'd6};
    logic [2:0] hl, l;
    logic       hz;
    for (int i = 0; i < 4; i++) begin
      highest = tab_high[i]; ocw2_data = tab_data[i]; ocw2_write = 1'b1;
      tick();
      ocw2_write = 1'b0;
      tests++;
      if (end_of_interrupt !== tab_eoi[i] || priority_rotate !== tab_rot[i] || latch_in_service !== 1'b0) begin
        fails++;
        $display("FAIL ocw2_table %h: got eoi %h rot %0d exp eoi %h rot %0d", tab_data[i],
                 end_of_interrupt, priority_rotate, tab_eoi[i], tab_rot[i]);
      end
    end
    exp_rot = 3'd6;
    for (int it = 0; it < 40; it++) begin
      hl = 3'($urandom_range(0, 7));
      hz = ($urandom_range(0, 3) == 0);
      highest = hz ? 8'h00 : (8'h01 << hl);
      ocw2_data = 8'($urandom); ocw2_write = 1'b1;
      l = ocw2_data[2:0];
      idle_exp();
      case (ocw2_data[7:5])
        3'b001: exp_eoi = highest;
        3'b011: exp_eoi = 8'h01 << l;
        3'b101: begin exp_eoi = highest; if (!hz) exp_rot = hl; end
        3'b111: begin exp_eoi = 8'h01 << l; exp_rot = l; end
        3'b110: exp_rot = l;
        3'b100: exp_raie = 1'b1;
        3'b000: exp_raie = 1'b0;
        default: ;
      endcase
      tick();
      ocw2_write = 1'b0;
      tests++;
      if (obs !== expv()) begin fails++; $display("FAIL ocw2_rand %h: got %h exp %h", ocw2_data, obs, expv()); end
      tick();
      idle_exp();
      tests++;
      if (obs !== expv()) begin fails++; $display("FAIL ocw2_after %h: got %h exp %h", ocw2_data, obs, expv()); end
    end
  endtask

  task automatic test_collision();
    icw4_upm = 1'b1; icw4_aeoi = 1'b1; highest = 8'h00;
    ocw2_data = 8'h80; ocw2_write = 1'b1;
    tick();
    ocw2_write = 1'b0; interrupt = 8'h02;
    inta_n = 1'b0; tick();
    inta_n = 1'b1; tick();
    inta_n = 1'b0; tick();
    tests++;
    if (vector_byte_select !== 2'd2 || acknowledged_level !== 3'd1) begin
      fails++; $display("FAIL coll_ack2: got sel %0d lvl %0d exp sel 2 lvl 1", vector_byte_select, acknowledged_level);
    end
    inta_n = 1'b1; ocw2_data = 8'hE4; ocw2_write = 1'b1;
    tick();
    ocw2_write = 1'b0;
    idle_exp(); exp_eoi = 8'h12; exp_rot = 3'd4; exp_lvl = 3'd1; exp_spur = 1'b0; exp_raie = 1'b1;
    tests++;
    if (obs !== expv()) begin fails++; $display("FAIL collision: got %h exp %h", obs, expv()); end
    tick();
    idle_exp();
    tests++;
    if (obs !== expv()) begin fails++; $display("FAIL coll_after: got %h exp %h", obs, expv()); end
  endtask

  task automatic test_reset_mid();
    icw4_upm = 1'b1; icw4_aeoi = 1'b0; interrupt = 8'h10;
    ocw2_data = 8'hC2; ocw2_write = 1'b1; tick(); ocw2_write = 1'b0;
    inta_n = 1'b0; tick();
    inta_n = 1'b1; tick();
    tests++;
    if (priority_rotate !== 3'd2 || acknowledged_level !== 3'd4) begin
      fails++; $display("FAIL rmid_pre: got rot %0d lvl %0d exp rot 2 lvl 4", priority_rotate, acknowledged_level);
    end
    reset_n = 1'b0;
    #1;
    reset_exp();
    tests++;
    if (obs !== expv()) begin fails++; $display("FAIL rmid_reset: got %h exp %h", obs, expv()); end
    tick();
    reset_n = 1'b1;
    tick();
    inta_n = 1'b0; tick();
    idle_exp(); exp_latch = 1'b1; exp_lvl = 3'd4;
    tests++;
    if (obs !== expv()) begin fails++; $display("FAIL rmid_fresh: got %h exp %h", obs, expv()); end
    inta_n = 1'b1; tick();
    inta_n = 1'b0; tick();
    idle_exp(); exp_voe = 1'b1; exp_sel = 2'd2;
    tests++;
    if (obs !== expv()) begin fails++; $display("FAIL rmid_second: got %h exp %h", obs, expv()); end
    inta_n = 1'b1; tick();
    idle_exp();
    tests++;
    if (obs !== expv()) begin fails++; $display("FAIL rmid_end: got %h exp %h", obs, expv()); end
  endtask

  task automatic test_icw1();
    icw4_upm = 1'b0; icw4_aeoi = 1'b1; interrupt = 8'h40;
    ocw2_data = 8'hC3; ocw2_write = 1'b1; tick(); ocw2_write = 1'b0;
    inta_n = 1'b0; tick();
    inta_n = 1'b1; tick();
    // ICW1 must beat an OCW2 set-priority written in the same cycle.
    icw1_write = 1'b1; ocw2_data = 8'hC5; ocw2_write = 1'b1;
    tick();
    icw1_write = 1'b0; ocw2_write = 1'b0;
    reset_exp();
    tests++;
    if (obs !== expv()) begin fails++; $display("FAIL icw1_clear: got %h exp %h", obs, expv()); end
    for (int p = 1; p <= 3; p++) begin
      inta_n = 1'b0; tick();
      idle_exp(); exp_latch = (p == 1); exp_lvl = 3'd6; exp_voe = 1'b1; exp_sel = 2'(p);
      tests++;
      if (obs !== expv()) begin fails++; $display("FAIL icw1_low p%0d: got %h exp %h", p, obs, expv()); end
      inta_n = 1'b1; tick();
      idle_exp();
      if (p == 3) exp_eoi = 8'h40;
      tests++;
      if (obs !== expv()) begin fails++; $display("FAIL icw1_rise p%0d: got %h exp %h", p, obs, expv()); end
    end
  endtask

  initial begin
    reset_exp();
    test_reset();
    test_ack();
    test_ocw2();
    test_collision();
    test_reset_mid();
    test_icw1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ack_eoi_controller_8259.md
Name: ack_eoi_controller_8259

Overview:
Sequences the 8259 interrupt-acknowledge cycle and all end-of-interrupt and priority-rotation operations for the in-service register block. It decodes the INTA pulse train (8086 two-pulse, 8080 three-pulse), pulses latch_in_service, and generates end_of_interrupt masks. It decodes OCW2 commands (non-specific, specific and rotating EOI; set priority; AEOI rotate mode) and drives the priority_rotate value shared by the in-service and priority-resolver blocks.

Parameters:
RESET_ROTATE, 3'b111, priority_rotate value after reset or ICW1 (IR0 highest priority).

Ports:
clock  input  1  block clock; all flops update on the falling edge, matching the in-service register.
reset_n  input  1  asynchronous active-low reset.
interrupt_acknowledge_n  input  1  INTA pin, already synchronized to clock.
interrupt  input  8  one-hot winning request from the priority resolver; 0 = none.
highest_level_in_service  input  8  one-hot highest in-service level, from the in-service register.
icw1_write  input  1  one-cycle strobe; re-initializes controller state.
icw4_upm  input  1  1 = 8086 mode (2 INTA pulses), 0 = 8080 mode (3 pulses).
icw4_aeoi  input  1  automatic EOI enable.
ocw2_write  input  1  one-cycle OCW2 write strobe.
ocw2_data  input  8  OCW2 byte: [7:5] = R,SL,EOI; [2:0] = L.
latch_in_service  output  1  one-cycle pulse that loads interrupt into the ISR.
end_of_interrupt  output  8  one-cycle mask of ISR bits to clear.
priority_rotate  output  3  lowest-priority level (rotation amount).
acknowledged_level  output  3  binary level captured at the first INTA.
spurious  output  1  high while the current ack cycle had no request.
vector_output_enable  output  1  high while a vector/address byte is to be driven.
vector_byte_select  output  2  1 = CALL opcode (8080), 2 = 1st byte, 3 = 2nd byte; 0 = idle.

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE; latch_in_service=0; end_of_interrupt=0; priority_rotate=RESET_ROTATE; acknowledged_level=0; spurious=0; vector_output_enable=0; vector_byte_select=0; rotate_in_aeoi=0. Reset mid-sequence aborts immediately; no EOI is issued.
- INTA edges: a previous-sample register (reset value 1) detects fall = prev&~cur and rise = ~prev&cur. All outputs are registered and respond on the clock after detection.
- States: IDLE, ACK1, ACK2, ACK3.
- IDLE + fall: latch_in_service=1 for exactly one cycle; capture acknowledged_level=encode(interrupt). If interrupt==0: spurious=1, acknowledged_level=7, no latch pulse. Go to ACK1. 8080 mode: vector_output_enable=1, select=1 while INTA is low.
- ACK1 + fall: go to ACK2; vector_output_enable=1 while INTA low; select = 2 (both modes).
- ACK2 + rise: 8086 mode ends the sequence; 8080 mode waits in ACK2. ACK2 + fall (8080 only): go to ACK3 with select=3.
- End of sequence is the rise of the final pulse (2nd in 8086, 3rd in 8080). Go to IDLE and clear spurious. If icw4_aeoi=1 and not spurious: end_of_interrupt = one-hot(acknowledged_level) for one cycle. If rotate_in_aeoi is also set: priority_rotate=acknowledged_level.
- Extra rises or falls not listed above are ignored.
- OCW2 decode, on ocw2_write, from R,SL,EOI:
  - 001: non-specific EOI; end_of_interrupt=highest_level_in_service.
  - 011: specific EOI; end_of_interrupt=1<<L.
  - 101: rotate on non-specific EOI; EOI as 001 and priority_rotate=encode(highest_level_in_service).
  - 111: rotate on specific EOI; end_of_interrupt=1<<L and priority_rotate=L.
  - 110: set priority; priority_rotate=L, no EOI.
  - 100: set rotate_in_aeoi. 000: clear rotate_in_aeoi. 010: no-op.
- Non-specific EOI or rotate with highest_level_in_service==0: no bits cleared, priority_rotate unchanged.
- Simultaneous events:
  - An AEOI end and an OCW2 EOI in the same cycle are OR'd into end_of_interrupt.
  - If both update priority_rotate, OCW2 wins.
  - OCW2 is honoured in any state.
- icw1_write: same effect as reset except it is synchronous. It takes priority over every other event in that cycle.
- end_of_interrupt and latch_in_service are 0 in every cycle without a qualifying event.

Test Plan:
- 8086 ack: interrupt=8'h08, two INTA pulses, aeoi=0 -> one latch_in_service pulse after the first fall; acknowledged_level=3; select 2 during the 2nd pulse; end_of_interrupt stays 0; state returns to IDLE.
- 8080 + AEOI + rotate_in_aeoi: interrupt=8'h20, OCW2=8'h80, three pulses -> select sequence 1,2,3; end_of_interrupt=8'h20 one cycle after the 3rd rise; priority_rotate=5.
- Spurious: interrupt=0 at the first fall -> no latch pulse; spurious=1; acknowledged_level=7; no AEOI EOI at end even with aeoi=1.
- OCW2: highest=8'h04, write 8'hA0 -> end_of_interrupt=8'h04 and priority_rotate=2. Write 8'h63 -> end_of_interrupt=8'h08. Write 8'hC6 -> priority_rotate=6, no EOI. Write 8'h20 with highest=0 -> nothing.
- Collision: AEOI end for level 1 in the same cycle as OCW2 8'hE4 -> end_of_interrupt=8'h12; priority_rotate=4.
- Reset: reset_n low between the 1st and 2nd INTA -> all outputs at reset values at once; priority_rotate=7; the next INTA fall starts a fresh ACK1.
